// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - tagged memory responder with fixed-latency load return
// Tags are allocated round-robin; loads travel a LATENCY-deep pipeline back to the requester.
module imem_responder #(
  parameter int LATENCY    = 4,
  parameter int NUM_TAGS   = 15,
  parameter int MEM_BLOCKS = 8192,
  parameter int TAG_W      = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       proc2Imem_command,
  input  logic [31:0]      proc2Imem_addr,
  input  logic [63:0]      proc2Imem_data,
  output logic [TAG_W-1:0] Imem2proc_transaction_tag,
  output logic [63:0]      Imem2proc_data,
  output logic [TAG_W-1:0] Imem2proc_data_tag,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [63:0]      dbg_data
);

  localparam logic [1:0] MEM_LOAD  = 2'h1;
  localparam logic [1:0] MEM_STORE = 2'h2;
  localparam int IDX_W = $clog2(MEM_BLOCKS);
  localparam int BW    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;
  localparam logic [TAG_W-1:0] ONE      = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(NUM_TAGS);

  logic [63:0] mem_q [MEM_BLOCKS];

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [TAG_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]    pipe_tag_q [LATENCY];
  logic [TAG_W-1:0]    pipe_tag_d [LATENCY];
  logic [63:0]         pipe_data_q [LATENCY];
  logic [63:0]         pipe_data_d [LATENCY];

  logic             is_load, is_store, alloc_found, accept, issue;
  logic [TAG_W-1:0] alloc_tag, head_tag;
  logic [63:0]      rd_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{proc2Imem_addr[2:0], proc2Imem_addr[31:3+IDX_W],
                              dbg_addr[2:0], dbg_addr[31:3+IDX_W]};

  assign is_load  = (proc2Imem_command == MEM_LOAD);
  assign is_store = (proc2Imem_command == MEM_STORE);
  assign rd_data  = mem_q[proc2Imem_addr[3 +: IDX_W]];
  assign head_tag = pipe_tag_q[LATENCY-1];

  // First free tag at or after rr_ptr, wrapping NUM_TAGS -> 1.
  always_comb begin
    alloc_found = 1'b0;
    alloc_tag   = '0;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (!alloc_found && !busy_q[BW'((int'(rr_ptr_q) + NUM_TAGS - 1 + i) % NUM_TAGS)]) begin
        alloc_found = 1'b1;
        alloc_tag   = TAG_W'((int'(rr_ptr_q) + NUM_TAGS - 1 + i) % NUM_TAGS + 1);
      end
    end
  end

  assign accept = !reset && alloc_found && (is_load || is_store);
  assign issue  = accept && is_load;
  assign Imem2proc_transaction_tag = accept ? alloc_tag : '0;

  always_comb begin
    busy_d = busy_q;
    if (head_tag != '0) busy_d[BW'(head_tag - ONE)] = 1'b0;
    if (issue) busy_d[BW'(alloc_tag - ONE)] = 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (alloc_tag == LAST_TAG) ? ONE : alloc_tag + ONE;

    pipe_tag_d[0]  = issue ? alloc_tag : '0;
    pipe_data_d[0] = issue ? rd_data : '0;
    for (int k = 1; k < LATENCY; k++) begin
      pipe_tag_d[k]  = pipe_tag_q[k-1];
      pipe_data_d[k] = pipe_data_q[k-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q   <= '0;
      rr_ptr_q <= ONE;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_tag_q[k]  <= '0;
        pipe_data_q[k] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_tag_q[k]  <= pipe_tag_d[k];
        pipe_data_q[k] <= pipe_data_d[k];
      end
    end
  end

  // Store is written after the preload so it wins a same-block collision.
  always_ff @(posedge clock) begin
    if (dbg_we) mem_q[dbg_addr[3 +: IDX_W]] <= dbg_data;
    if (accept && is_store) mem_q[proc2Imem_addr[3 +: IDX_W]] <= proc2Imem_data;
  end

  assign Imem2proc_data_tag = head_tag;
  assign Imem2proc_data     = pipe_data_q[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
module tb_imem_responder;
  localparam int LAT = 4;
  localparam logic [1:0] NONE = 2'h0, LOAD = 2'h1, STORE = 2'h2;
  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;

  logic        clock, reset;
  logic [1:0]  command;
  logic [31:0] addr;
  logic [63:0] wdata;
  logic [3:0]  ttag, dtag;
  logic [63:0] rdata;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [63:0] dbg_data;

  logic [1:0]  ex_command;
  logic [31:0] ex_addr;
  logic [3:0]  ex_ttag, ex_dtag;
  logic [63:0] ex_rdata;
  logic        ex_dbg_we;
  logic [31:0] ex_dbg_addr;
  logic [63:0] ex_dbg_data;

  imem_responder dut (
    .clock(clock), .reset(reset),
    .proc2Imem_command(command), .proc2Imem_addr(addr), .proc2Imem_data(wdata),
    .Imem2proc_transaction_tag(ttag), .Imem2proc_data(rdata), .Imem2proc_data_tag(dtag),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  imem_responder #(.LATENCY(8), .NUM_TAGS(3)) dut_ex (
    .clock(clock), .reset(reset),
    .proc2Imem_command(ex_command), .proc2Imem_addr(ex_addr), .proc2Imem_data(64'h0),
    .Imem2proc_transaction_tag(ex_ttag), .Imem2proc_data(ex_rdata), .Imem2proc_data_tag(ex_dtag),
    .dbg_we(ex_dbg_we), .dbg_addr(ex_dbg_addr), .dbg_data(ex_dbg_data)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] data;
    int          due;
  } resp_t;

  resp_t sb[$];
  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  logic mon_en = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Every cycle the response port must match the head of the scoreboard or be idle.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [3:0]  et;
      logic [63:0] ed;
      et = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        et = sb[0].tag;
        ed = sb[0].data;
        void'(sb.pop_front());
      end
      total_cnt++;
      if (dtag !== et || rdata !== ed)
        $display("FAIL response cyc %0d: got tag %0d data %h, expected tag %0d data %h",
                 cyc, dtag, rdata, et, ed);
      else
        pass_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_data = d;
    @(posedge clock); #1;
    dbg_we = 1'b0;
  endtask

  task automatic issue(input logic [1:0] cmd, input logic [31:0] a, input logic [63:0] d,
                       input logic [3:0] exp_tag, input logic [63:0] exp_data, input string name);
    command = cmd; addr = a; wdata = d;
    @(negedge clock);
    total_cnt++;
    if (ttag !== exp_tag)
      $display("FAIL %s: transaction_tag got %0d, expected %0d", name, ttag, exp_tag);
    else
      pass_cnt++;
    if (cmd == LOAD && exp_tag != 0) sb.push_back('{exp_tag, exp_data, cyc + LAT});
    @(posedge clock); #1;
    command = NONE;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    command = LOAD; addr = 32'h80;
    @(negedge clock);
    total_cnt++;
    if (ttag !== 4'd0) $display("FAIL reset_tag: got %0d, expected 0", ttag);
    else pass_cnt++;
    @(posedge clock); #1;
    command = NONE;
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    preload(32'h80, DEAD);
    issue(LOAD, 32'h80, 64'h0, 4'd1, DEAD, "single_load");
    idle(6);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) preload(32'h200 + 8 * i, 64'hB0B0_0000 + 64'(i));
    do_reset();
    for (int i = 0; i < 6; i++)
      issue(LOAD, 32'h200 + 8 * i, 64'h0, 4'(i + 1), 64'hB0B0_0000 + 64'(i), "b2b");
    idle(6);
  endtask

  task automatic test_store_then_load();
    do_reset();
    issue(STORE, 32'h100, 64'h1234, 4'd1, 64'h0, "store_tag");
    issue(LOAD, 32'h104, 64'h0, 4'd2, 64'h1234, "raw_load");
    idle(6);
    preload(32'h300, 64'h0BAD);
    issue(LOAD, 32'h300, 64'h0, 4'd3, 64'h0BAD, "load_before_store");
    issue(STORE, 32'h300, 64'h600D, 4'd4, 64'h0, "store_after_load");
    issue(LOAD, 32'h300, 64'h0, 4'd5, 64'h600D, "load_after_store");
    idle(6);
    dbg_we = 1'b1; dbg_addr = 32'h308; dbg_data = 64'h0DB6;
    issue(STORE, 32'h308, 64'h5707, 4'd6, 64'h0, "store_vs_dbg");
    dbg_we = 1'b0;
    issue(LOAD, 32'h308, 64'h0, 4'd7, 64'h5707, "store_wins");
    idle(6);
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int i = 0; i < 3; i++) issue(LOAD, 32'h80, 64'h0, 4'(i + 1), DEAD, "midflight_load");
    do_reset();
    idle(8);
    issue(LOAD, 32'h80, 64'h0, 4'd1, DEAD, "after_reset_tag");
    idle(6);
  endtask

  task automatic test_exhaustion();
    logic [3:0] et, edt;
    logic [63:0] ed;
    for (int i = 0; i < 12; i++) begin
      ex_dbg_we = 1'b1; ex_dbg_addr = 32'(8 * i); ex_dbg_data = 64'hA000 + 64'(i);
      @(posedge clock); #1;
    end
    ex_dbg_we = 1'b0;
    for (int i = 0; i < 17; i++) begin
      ex_command = (i < 12) ? LOAD : NONE;
      ex_addr = 32'(8 * i);
      @(negedge clock);
      if (i < 12) begin
        et = (i < 3) ? 4'(i + 1) : (i < 9) ? 4'd0 : 4'(i - 8);
        total_cnt++;
        if (ex_ttag !== et) $display("FAIL exhaust_tag i=%0d: got %0d, expected %0d", i, ex_ttag, et);
        else pass_cnt++;
      end
      edt = (i >= 8 && i <= 10) ? 4'(i - 7) : 4'd0;
      ed = (edt != 0) ? 64'hA000 + 64'(i - 8) : 64'h0;
      total_cnt++;
      if (ex_dtag !== edt || ex_rdata !== ed)
        $display("FAIL exhaust_resp i=%0d: got tag %0d data %h, expected tag %0d data %h",
                 i, ex_dtag, ex_rdata, edt, ed);
      else pass_cnt++;
      @(posedge clock); #1;
    end
    ex_command = NONE;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      issue(LOAD, 32'h80, 64'h0, 4'((k % 15) + 1), DEAD, "rr_wrap");
      idle(5);
    end
    idle(4);
  endtask

  initial begin
    reset = 1'b1; command = NONE; addr = '0; wdata = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
    ex_command = NONE; ex_addr = '0; ex_dbg_we = 1'b0; ex_dbg_addr = '0; ex_dbg_data = '0;
    @(posedge clock); #1;
    mon_en = 1'b1;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_store_then_load();
    test_reset_midflight();
    test_exhaustion();
    test_round_robin();
    total_cnt++;
    if (sb.size() != 0) $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
# imem_responder

Memory-side responder for the tagged memory interface used by the non-blocking instruction cache. It accepts one command per cycle and returns a transaction tag in the same cycle, or 0 to reject. Load data comes back a fixed number of cycles later, marked with the matching tag. The block provides a cycle-accurate memory model and also serves as the memory front-end that the icache and its MSHR are tested against.

## Interface
- LATENCY, 4: cycles from load accept to data return; legal range 1..32
- NUM_TAGS, 15: usable tags 1..NUM_TAGS; tag 0 means "none/rejected"; must fit MEM_TAG
- MEM_BLOCKS, 8192: backing store depth in MEM_BLOCKs, indexed by addr[15:3]
- clock  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high
- proc2Imem_command  in  MEM_COMMAND  MEM_NONE / MEM_LOAD / MEM_STORE
- proc2Imem_addr  in  ADDR  byte address; bits [2:0] and above [15] ignored
- proc2Imem_data  in  MEM_BLOCK  store data
- Imem2proc_transaction_tag  out  MEM_TAG  same-cycle tag for the current command; 0 = not accepted
- Imem2proc_data  out  MEM_BLOCK  load data; valid only when data_tag != 0
- Imem2proc_data_tag  out  MEM_TAG  tag of the returning load; 0 = no response this cycle
- dbg_we  in  1  testbench preload write enable
- dbg_addr  in  ADDR  preload byte address
- dbg_data  in  MEM_BLOCK  preload data

## Operation
- Tag table: one busy bit per tag 1..NUM_TAGS. Round-robin pointer rr_ptr ranges over 1..NUM_TAGS and resets to 1.
- Allocation: scan for the first free tag starting at rr_ptr and wrapping NUM_TAGS→1. rr_ptr becomes (allocated tag mod NUM_TAGS)+1.
- No free tag: transaction_tag = 0. The command has no effect: no store write, no load issue, rr_ptr unchanged.
- MEM_NONE: transaction_tag = 0, no state change.
- MEM_LOAD accepted:
  - The block reads mem[addr[15:3]] in the accept cycle.
  - The tag and data enter a LATENCY-deep response shift pipeline.
  - The tag is marked busy.
- MEM_STORE accepted:
  - proc2Imem_data is written to mem[addr[15:3]] at the accept-cycle edge.
  - A nonzero tag is returned, but no data response ever follows. The tag is never marked busy and rr_ptr still advances.
- Response: the pipeline head drives Imem2proc_data_tag and Imem2proc_data.
  - The busy bit of the head tag clears at the end of that cycle.
  - The tag can be allocated again starting the following cycle.
- Ordering: fixed latency, so responses return in accept order, at most one per cycle.
- Read-after-write:
  - A load accepted the cycle after a store to the same block returns the new data.
  - A store accepted after a load was accepted does not change that load's in-flight data.
- dbg_we writes mem[dbg_addr[15:3]] at the edge. If it collides with an accepted store to the same block in the same cycle, the store wins.
- Memory contents are not cleared by reset.

## Timing
- transaction_tag is combinational from command, busy bits and rr_ptr. It is forced to 0 while reset is high.
- A load accepted in cycle t has data_tag and data valid for exactly cycle t+LATENCY. Its tag is free in t+LATENCY+1.
- Imem2proc_data and Imem2proc_data_tag are registered outputs. Both are 0 in the cycle after reset and whenever no response is due. Data is 0 when the tag is 0.
- Reset at any point:
  - The pipeline is flushed and in-flight loads never respond.
  - All busy bits are cleared and rr_ptr = 1.
  - Stores already performed persist.
- Maximum in-flight loads is min(NUM_TAGS, LATENCY+1).

## Test plan
- Single load: preload block 0x10 = 64'hDEAD_BEEF_0000_0001; then MEM_LOAD addr 0x80 at t. Required response: transaction_tag = 1 at t; data_tag = 1 and data = the preloaded value at t+4; data_tag = 0 at every other cycle.
- Back-to-back loads: loads on 6 consecutive cycles. Required response: tags 1,2,3,4,5,6; responses on 6 consecutive cycles starting 4 cycles after the first, in the same order.
- Tag exhaustion: NUM_TAGS=3, LATENCY=8, load every cycle.
  - 4th load gets tag 0 and never responds.
  - Tag 1 is reallocated in the cycle after its response.
- Store then load: MEM_STORE addr 0x100 data 64'h1234 at t; MEM_LOAD addr 0x104 at t+1. Required response: the store gets a nonzero tag with no data response; the load returns 64'h1234 at t+1+LATENCY.
- Reset mid-flight: 3 loads issued, then reset for 1 cycle before any response. Required response: no data_tag != 0 afterwards; the next load gets tag 1.
- Round-robin wrap: with NUM_TAGS=15, issue 16 spaced loads. Required response: the tags cycle 1..15, then 1.
